evt_track_array: RTL and testbench

EVT_TRACK_ARRAY -- requirements
Module: evt_track_array

---
 rtl/evt_track_array.sv | 88 ++++++++
 tb/tb_evt_track_array.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/evt_track_array.sv
// Per-channel event tracker, XOR/OR accumulator and saturating counter; NCH independent channels.
// Latency: inputs flopped once, then tracker/accumulator, then g/h output flops; no backpressure.
module evt_track_array #(
  parameter int NCH = 4,
  parameter int CW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              clr,
  input  logic [NCH-1:0]    e,
  input  logic [NCH-1:0]    f,
  output logic [NCH-1:0]    g,
  output logic [NCH-1:0]    h,
  output logic [NCH*CW-1:0] cnt,
  output logic [NCH-1:0]    sat
);

  localparam logic [CW-1:0] CMAX = '1;

  logic [NCH-1:0] ed, fd, tog, stk, gpre, hpre;
  logic [NCH-1:0] gpre_nxt, tog_nxt, stk_nxt;
  logic           ph;
  logic           trk_en;
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_nxt [NCH];

  assign trk_en = ~mode | ph;

  always_comb begin
    gpre_nxt = (tog & (gpre ^ ed)) | (~tog & stk & (gpre | hpre)) | (~tog & ~stk & gpre);
    tog_nxt  = tog;
    stk_nxt  = stk;
    if (trk_en) begin
      // ed wins over fd, so fd only feeds stk on cycles without a primary event
      tog_nxt = tog ^ ed;
      stk_nxt = stk | (~ed & fd & tog);
    end
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (ed[i] && tog[i] && (cnt_q[i] != CMAX)) cnt_nxt[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ed   <= '0;
      fd   <= '0;
      ph   <= 1'b0;
      tog  <= '0;
      stk  <= '0;
      gpre <= '0;
      hpre <= '0;
      g    <= '0;
      h    <= '0;
      sat  <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      ed <= e;
      fd <= f;
      ph <= ~ph;
      g  <= gpre;
      h  <= hpre;
      if (clr) begin
        tog  <= '0;
        stk  <= '0;
        gpre <= '0;
        hpre <= '0;
        sat  <= '0;
        for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
        tog  <= tog_nxt;
        stk  <= stk_nxt;
        gpre <= gpre_nxt;
        hpre <= gpre & ed;
        for (int i = 0; i < NCH; i++) begin
          cnt_q[i] <= cnt_nxt[i];
          sat[i]   <= (cnt_nxt[i] == CMAX);
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    assign cnt[i*CW +: CW] = cnt_q[i];
  end

endmodule

// File: tb/tb_evt_track_array.sv
// Directed and random stimulus against a cycle-level reference model of the channel rules.
module tb_evt_track_array;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mode = 1'b0;
  logic              clr = 1'b0;
  logic [NCH-1:0]    e = '0;
  logic [NCH-1:0]    f = '0;
  logic [NCH-1:0]    g, h, sat;
  logic [NCH*CW-1:0] cnt;

  int ncmp = 0;
  int nfail = 0;

  int m_ph;
  int m_ed[NCH], m_fd[NCH], m_tog[NCH], m_stk[NCH];
  int m_gp[NCH], m_hp[NCH], m_g[NCH], m_h[NCH], m_cnt[NCH];

  evt_track_array #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .clr(clr),
    .e(e), .f(f), .g(g), .h(h), .cnt(cnt), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, using the inputs held across that edge
  task automatic model_step();
    int en;
    if (rst) begin
      m_ph = 0;
      for (int i = 0; i < NCH; i++) begin
        m_ed[i] = 0; m_fd[i] = 0; m_tog[i] = 0; m_stk[i] = 0;
        m_gp[i] = 0; m_hp[i] = 0; m_g[i] = 0; m_h[i] = 0; m_cnt[i] = 0;
      end
      return;
    end
    en = (mode == 1'b0) || (m_ph == 1);
    for (int i = 0; i < NCH; i++) begin
      int n_tog, n_stk, n_gp, n_hp, n_cnt;
      n_tog = m_tog[i];
      n_stk = m_stk[i];
      if (en) begin
        if (m_ed[i] == 1) n_tog = 1 - m_tog[i];
        else if (m_fd[i] == 1) n_stk = m_tog[i] | m_stk[i];
      end
      n_hp = m_gp[i] & m_ed[i];
      if (m_tog[i] == 1) n_gp = m_gp[i] ^ m_ed[i];
      else if (m_stk[i] == 1) n_gp = m_gp[i] | m_hp[i];
      else n_gp = m_gp[i];
      n_cnt = m_cnt[i];
      if (m_ed[i] == 1 && m_tog[i] == 1 && n_cnt < CMAX) n_cnt = n_cnt + 1;
      if (clr) begin
        n_tog = 0; n_stk = 0; n_gp = 0; n_hp = 0; n_cnt = 0;
      end
      m_g[i]   = m_gp[i];
      m_h[i]   = m_hp[i];
      m_tog[i] = n_tog;
      m_stk[i] = n_stk;
      m_gp[i]  = n_gp;
      m_hp[i]  = n_hp;
      m_cnt[i] = n_cnt;
      m_ed[i]  = int'(e[i]);
      m_fd[i]  = int'(f[i]);
    end
    m_ph = 1 - m_ph;
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0]    xg, xh, xs;
    logic [NCH*CW-1:0] xc;
    for (int i = 0; i < NCH; i++) begin
      xg[i] = m_g[i][0];
      xh[i] = m_h[i][0];
      xs[i] = (m_cnt[i] == CMAX);
      xc[i*CW +: CW] = m_cnt[i][CW-1:0];
    end
    chk({tag, "_g"},   32'(g),   32'(xg));
    chk({tag, "_h"},   32'(h),   32'(xh));
    chk({tag, "_cnt"}, 32'(cnt), 32'(xc));
    chk({tag, "_sat"}, 32'(sat), 32'(xs));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    // reset
    tick("rst");
    tick("rst");
    chk("rst_g", 32'(g), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);

    // primary event on channel 0 for two sampled edges
    rst = 1'b0; mode = 1'b0; e = 4'b0001;
    tick("r27");
    tick("r27");
    e = 4'b0000;
    tick("r27");
    tick("r27");
    chk("r27_g", 32'(g), 32'h1);
    chk("r27_cnt", 32'(cnt), 32'h1);

    // single sampled event leaves the accumulator clear
    clr = 1'b1;
    tick("clr");
    clr = 1'b0;
    tick("idle");
    e = 4'b0001;
    tick("r28");
    e = 4'b0000;
    for (int k = 0; k < 4; k++) tick("r28");
    chk("r28_g", 32'(g), 32'h0);
    chk("r28_cnt", 32'(cnt), 32'h0);

    // channel 1 saturation
    clr = 1'b1;
    tick("clr");
    clr = 1'b0;
    e = 4'b0010;
    for (int k = 0; k < 14; k++) tick("r29");
    chk("r29_cnt1", 32'(cnt[3:2]), 32'd3);
    chk("r29_sat1", 32'(sat[1]), 32'd1);
    e = 4'b0000;

    // gated tracker on channel 2, then ungated for comparison
    clr = 1'b1;
    tick("clr");
    clr = 1'b0; mode = 1'b1; e = 4'b0100;
    for (int k = 0; k < 6; k++) tick("r30m1");
    clr = 1'b1; e = 4'b0000;
    tick("clr");
    clr = 1'b0; mode = 1'b0; e = 4'b0100;
    for (int k = 0; k < 6; k++) tick("r30m0");

    // clear while channel 0 is busy
    clr = 1'b1; e = 4'b0000;
    tick("clr");
    clr = 1'b0; e = 4'b0001;
    for (int k = 0; k < 5; k++) tick("r31pre");
    clr = 1'b1;
    tick("r31clr");
    clr = 1'b0;
    tick("r31post");
    chk("r31_g0", 32'(g[0]), 32'd0);
    chk("r31_cnt0", 32'(cnt[1:0]), 32'd0);

    // random traffic with occasional mode flips, clears and resets
    for (int k = 0; k < 400; k++) begin
      e = 4'($urandom);
      f = 4'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      tick("rnd");
    end

    // reset mid-stream with all channels active
    rst = 1'b0; clr = 1'b0; mode = 1'b0; e = '1; f = '1;
    for (int k = 0; k < 6; k++) tick("r32pre");
    rst = 1'b1;
    tick("r32rst");
    chk("r32_g", 32'(g), 32'd0);
    chk("r32_h", 32'(h), 32'd0);
    chk("r32_cnt", 32'(cnt), 32'd0);
    chk("r32_sat", 32'(sat), 32'd0);
    rst = 1'b0; mode = 1'b1;
    for (int k = 0; k < 8; k++) tick("r32post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
